// File: rtl/axi_firewall_pkg.sv
// Shared constants, response codes and sequencer state encoding for the
// firewall CTL-port sequencer.
package axi_firewall_pkg;

  localparam logic [11:0] STATUS_OFFSET  = 12'h000;
  localparam logic [11:0] UNBLOCK_OFFSET = 12'h008;

  localparam logic [1:0]  RESP_OKAY      = 2'b00;

  localparam logic [31:0] UNBLOCK_DATA   = 32'h0000_0001;
  localparam logic [3:0]  UNBLOCK_STRB   = 4'h1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_R,
    ST_WR,
    ST_WR_B,
    ST_WAIT_CLEAR,
    ST_HOLDOFF
  } seq_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_firewall_ctl_regs.sv
// Status capture, saturating unblock counter and sticky control-error flag.
// Every output updates one cycle after its strobe; strobes are never stalled.
module axi_firewall_ctl_regs
  import axi_firewall_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_done,
  input  logic [31:0]        rdata,
  input  logic               wr_done,
  input  logic               resp_err,
  input  logic               timeout,
  output logic [31:0]        fault_status,
  output logic [COUNT_W-1:0] unblock_count,
  output logic               ctl_error
);

  logic [31:0]        fault_status_q,  fault_status_d;
  logic [COUNT_W-1:0] unblock_count_q, unblock_count_d;
  logic               ctl_error_q,     ctl_error_d;

  always_comb begin
    fault_status_d  = fault_status_q;
    unblock_count_d = unblock_count_q;
    ctl_error_d     = ctl_error_q | resp_err | timeout;
    // Captured regardless of rresp so a failing read is still visible to debug.
    if (rd_done) begin
      fault_status_d = rdata;
    end
    if (wr_done && (unblock_count_q != {COUNT_W{1'b1}})) begin
      unblock_count_d = unblock_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_status_q  <= '0;
      unblock_count_q <= '0;
      ctl_error_q     <= 1'b0;
    end else begin
      fault_status_q  <= fault_status_d;
      unblock_count_q <= unblock_count_d;
      ctl_error_q     <= ctl_error_d;
    end
  end

  assign fault_status  = fault_status_q;
  assign unblock_count = unblock_count_q;
  assign ctl_error     = ctl_error_q;

endmodule

// File: rtl/axi_firewall_ctl_sequencer.sv
// Clears sticky firewall MI errors: status read, unblock write, poll for clear, hold-off.
// One AXI-Lite transaction at a time; each phase waits indefinitely on its slave handshake.
module axi_firewall_ctl_sequencer
  import axi_firewall_pkg::*;
#(
  parameter logic [11:0] STATUS_ADDR  = STATUS_OFFSET,
  parameter logic [11:0] UNBLOCK_ADDR = UNBLOCK_OFFSET,
  parameter int          POLL_LIMIT   = 256,
  parameter int          HOLDOFF      = 16,
  parameter int          COUNT_W      = 16
) (
  input  logic               aclk,
  input  logic               areset,
  output logic [11:0]        M_AXI_CTL_AWADDR,
  output logic [2:0]         M_AXI_CTL_AWPROT,
  output logic               M_AXI_CTL_AWVALID,
  input  logic               M_AXI_CTL_AWREADY,
  output logic [31:0]        M_AXI_CTL_WDATA,
  output logic [3:0]         M_AXI_CTL_WSTRB,
  output logic               M_AXI_CTL_WVALID,
  input  logic               M_AXI_CTL_WREADY,
  input  logic [1:0]         M_AXI_CTL_BRESP,
  input  logic               M_AXI_CTL_BVALID,
  output logic               M_AXI_CTL_BREADY,
  output logic [11:0]        M_AXI_CTL_ARADDR,
  output logic [2:0]         M_AXI_CTL_ARPROT,
  output logic               M_AXI_CTL_ARVALID,
  input  logic               M_AXI_CTL_ARREADY,
  input  logic [31:0]        M_AXI_CTL_RDATA,
  input  logic [1:0]         M_AXI_CTL_RRESP,
  input  logic               M_AXI_CTL_RVALID,
  output logic               M_AXI_CTL_RREADY,
  input  logic               mi_w_error,
  input  logic               mi_r_error,
  output logic [31:0]        fault_status,
  output logic [COUNT_W-1:0] unblock_count,
  output logic               busy,
  output logic               ctl_error
);

  localparam int CNT_MAX = (POLL_LIMIT > HOLDOFF) ? POLL_LIMIT : HOLDOFF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;

  logic err, ar_hs, r_hs, b_hs, aw_pend, w_pend;
  logic rd_done, wr_done, resp_err, timeout;

  assign err     = mi_w_error | mi_r_error;
  assign ar_hs   = arvalid_q & M_AXI_CTL_ARREADY;
  assign r_hs    = rready_q  & M_AXI_CTL_RVALID;
  assign b_hs    = bready_q  & M_AXI_CTL_BVALID;
  assign aw_pend = awvalid_q & ~M_AXI_CTL_AWREADY;
  assign w_pend  = wvalid_q  & ~M_AXI_CTL_WREADY;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
    end
  end

  // One counter serves both the poll timeout and the hold-off; each reuse starts at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (err)  state_d = ST_RD_A;
      ST_RD_A:  if (ar_hs) state_d = ST_RD_R;
      ST_RD_R:  if (r_hs)  state_d = ST_WR;
      ST_WR:    if (!aw_pend && !w_pend) state_d = ST_WR_B;
      ST_WR_B: begin
        if (b_hs) begin
          state_d = ST_WAIT_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_WAIT_CLEAR: begin
        if (!err) begin
          state_d = ST_HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(POLL_LIMIT)) begin
            timeout = 1'b1;
            state_d = ST_HOLDOFF;
            cnt_d   = '0;
          end
        end
      end
      ST_HOLDOFF: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CNT_W'(HOLDOFF)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    arvalid_d = (state_q == ST_IDLE && err) || (state_q == ST_RD_A && !ar_hs);
    rready_d  = (state_q == ST_RD_A && ar_hs) || (state_q == ST_RD_R && !r_hs);
    awvalid_d = (state_q == ST_RD_R && r_hs) || (state_q == ST_WR && aw_pend);
    wvalid_d  = (state_q == ST_RD_R && r_hs) || (state_q == ST_WR && w_pend);
    bready_d  = (state_q == ST_WR && !aw_pend && !w_pend) || (state_q == ST_WR_B && !b_hs);
    rd_done   = (state_q == ST_RD_R) && r_hs;
    wr_done   = (state_q == ST_WR_B) && b_hs;
    resp_err  = (rd_done && resp_is_err(M_AXI_CTL_RRESP)) ||
                (wr_done && resp_is_err(M_AXI_CTL_BRESP));
  end

  axi_firewall_ctl_regs #(
    .COUNT_W (COUNT_W)
  ) u_regs (
    .clk           (aclk),
    .rst           (areset),
    .rd_done       (rd_done),
    .rdata         (M_AXI_CTL_RDATA),
    .wr_done       (wr_done),
    .resp_err      (resp_err),
    .timeout       (timeout),
    .fault_status  (fault_status),
    .unblock_count (unblock_count),
    .ctl_error     (ctl_error)
  );

  assign M_AXI_CTL_ARADDR  = STATUS_ADDR;
  assign M_AXI_CTL_ARPROT  = 3'b000;
  assign M_AXI_CTL_ARVALID = arvalid_q;
  assign M_AXI_CTL_RREADY  = rready_q;
  assign M_AXI_CTL_AWADDR  = UNBLOCK_ADDR;
  assign M_AXI_CTL_AWPROT  = 3'b000;
  assign M_AXI_CTL_AWVALID = awvalid_q;
  assign M_AXI_CTL_WDATA   = UNBLOCK_DATA;
  assign M_AXI_CTL_WSTRB   = UNBLOCK_STRB;
  assign M_AXI_CTL_WVALID  = wvalid_q;
  assign M_AXI_CTL_BREADY  = bready_q;
  assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi_firewall_ctl_sequencer.sv
// Directed bench for the firewall CTL sequencer with a small reactive AXI-Lite slave.
module tb_axi_firewall_ctl_sequencer;

  localparam int PL = 10;
  localparam int HO = 6;
  localparam int CW = 2;
  localparam int SEL_R = 0, SEL_W = 1, SEL_B = 2;

  logic        aclk, areset;
  logic [11:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, fault_status;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        mi_w_error, mi_r_error, busy, ctl_error;
  logic [CW-1:0] unblock_count;

  int n_checks = 0, n_errors = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, viol = 0;
  logic r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;

  int          cfg_aw_delay = 0, cfg_w_delay = 0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;
  logic        spur = 1'b0;

  axi_firewall_ctl_sequencer #(
    .POLL_LIMIT (PL),
    .HOLDOFF    (HO),
    .COUNT_W    (CW)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .M_AXI_CTL_AWADDR  (awaddr),
    .M_AXI_CTL_AWPROT  (awprot),
    .M_AXI_CTL_AWVALID (awvalid),
    .M_AXI_CTL_AWREADY (awready),
    .M_AXI_CTL_WDATA   (wdata),
    .M_AXI_CTL_WSTRB   (wstrb),
    .M_AXI_CTL_WVALID  (wvalid),
    .M_AXI_CTL_WREADY  (wready),
    .M_AXI_CTL_BRESP   (bresp),
    .M_AXI_CTL_BVALID  (bvalid),
    .M_AXI_CTL_BREADY  (bready),
    .M_AXI_CTL_ARADDR  (araddr),
    .M_AXI_CTL_ARPROT  (arprot),
    .M_AXI_CTL_ARVALID (arvalid),
    .M_AXI_CTL_ARREADY (arready),
    .M_AXI_CTL_RDATA   (rdata),
    .M_AXI_CTL_RRESP   (rresp),
    .M_AXI_CTL_RVALID  (rvalid),
    .M_AXI_CTL_RREADY  (rready),
    .mi_w_error        (mi_w_error),
    .mi_r_error        (mi_r_error),
    .fault_status      (fault_status),
    .unblock_count     (unblock_count),
    .busy              (busy),
    .ctl_error         (ctl_error)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Handshake monitor: sees pre-edge values of every channel.
  always @(posedge aclk) begin
    if (areset) begin
      r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    end else begin
      if (arvalid && (awvalid || wvalid || rready || bready)) viol++;
      if (arvalid && arready) begin ar_cnt++; r_pend = 1; end
      if (rvalid && rready)   begin r_cnt++;  r_pend = 0; end
      if (awvalid && awready) begin aw_cnt++; aw_got = 1; end
      if (wvalid && wready)   begin w_cnt++;  w_got = 1; end
      if (aw_got && w_got)    begin b_pend = 1; aw_got = 0; w_got = 0; end
      if (bvalid && bready)   begin b_cnt++;  b_pend = 0; end
    end
  end

  // Slave: drives its inputs on the falling edge.
  initial begin
    int aw_wait, w_wait;
    aw_wait = 0; w_wait = 0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rdata = '0; rresp = 2'b00; bresp = 2'b00;
    forever begin
      @(negedge aclk);
      arready = 1'b1;
      if (awvalid) aw_wait++; else aw_wait = 0;
      if (wvalid)  w_wait++;  else w_wait = 0;
      awready = awvalid && (aw_wait > cfg_aw_delay);
      wready  = wvalid  && (w_wait  > cfg_w_delay);
      rvalid  = r_pend | spur;
      rdata   = cfg_rdata;
      rresp   = cfg_rresp;
      bvalid  = b_pend | spur;
      bresp   = cfg_bresp;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  function automatic int sel_cnt(input int which);
    return (which == SEL_R) ? r_cnt : (which == SEL_W) ? w_cnt : b_cnt;
  endfunction

  task automatic wait_until(input int which, input int target, input string tag);
    int i, cur;
    i = 0;
    cur = sel_cnt(which);
    while (cur < target && i < 300) begin
      @(negedge aclk);
      i++;
      cur = sel_cnt(which);
    end
    if (cur < target) check({tag, "_timeout"}, cur, target);
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (busy && i < 300) begin
      @(negedge aclk);
      i++;
    end
    if (busy) check({tag, "_idle_timeout"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    mi_w_error = 1'b0; mi_r_error = 1'b0;
    cfg_aw_delay = 0; cfg_w_delay = 0;
    cfg_rresp = 2'b00; cfg_bresp = 2'b00; spur = 1'b0;
    tick(2);
    areset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    areset = 1'b1; mi_w_error = 1'b0; mi_r_error = 1'b0;
    do_reset();

    check("rst_arvalid", arvalid, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fault", fault_status, 32'h0);
    check("rst_count", unblock_count, 2'd0);
    check("rst_ctlerr", ctl_error, 1'b0);
    check("araddr", araddr, 12'h000);
    check("awaddr", awaddr, 12'h008);
    check("wdata", wdata, 32'h1);
    check("wstrb", wstrb, 4'h1);

    // Basic unblock episode.
    cfg_rdata = 32'h0000_0104;
    mi_w_error = 1'b1;
    tick(1);
    check("t1_arvalid", arvalid, 1'b1);
    check("t1_busy", busy, 1'b1);
    wait_until(SEL_B, 1, "t1_b");
    tick(3);
    mi_w_error = 1'b0;
    tick(HO);
    check("t1_busy_holdoff", busy, 1'b1);
    tick(1);
    check("t1_busy_done", busy, 1'b0);
    check("t1_fault", fault_status, 32'h104);
    check("t1_count", unblock_count, 2'd1);
    check("t1_ctlerr", ctl_error, 1'b0);
    check("t1_ar", ar_cnt, 1);
    check("t1_aw", aw_cnt, 1);
    check("t1_w", w_cnt, 1);

    // Stray R/B beats in IDLE are ignored.
    cfg_rdata = 32'hFFFF_0000;
    spur = 1'b1;
    tick(3);
    spur = 1'b0;
    tick(2);
    check("spur_busy", busy, 1'b0);
    check("spur_fault", fault_status, 32'h104);
    check("spur_count", unblock_count, 2'd1);

    // AWREADY trails WREADY by four cycles.
    do_reset();
    cfg_aw_delay = 4;
    cfg_rdata = 32'h0000_0022;
    base = w_cnt;
    mi_r_error = 1'b1;
    wait_until(SEL_W, base + 1, "t2_w");
    check("t2_wvalid_drop", wvalid, 1'b0);
    check("t2_awvalid_held", awvalid, 1'b1);
    tick(2);
    check("t2_awvalid_still", awvalid, 1'b1);
    base = b_cnt;
    wait_until(SEL_B, base + 1, "t2_b");
    mi_r_error = 1'b0;
    wait_idle("t2");
    tick(2);
    check("t2_one_b", b_cnt - base, 1);
    check("t2_count", unblock_count, 2'd1);
    check("t2_ctlerr", ctl_error, 1'b0);

    // Error never clears: poll timeout then a second episode.
    do_reset();
    base = b_cnt;
    mi_w_error = 1'b1;
    wait_until(SEL_B, base + 1, "t3_b1");
    check("t3_ctlerr_pre", ctl_error, 1'b0);
    tick(PL - 1);
    check("t3_ctlerr_edge", ctl_error, 1'b0);
    tick(1);
    check("t3_ctlerr_timeout", ctl_error, 1'b1);
    tick(HO);
    check("t3_idle_busy", busy, 1'b0);
    check("t3_idle_arvalid", arvalid, 1'b0);
    tick(1);
    check("t3_rearm_arvalid", arvalid, 1'b1);
    wait_until(SEL_B, base + 2, "t3_b2");
    mi_w_error = 1'b0;
    wait_idle("t3");
    check("t3_count", unblock_count, 2'd2);
    check("t3_ctlerr_sticky", ctl_error, 1'b1);

    // SLVERR on the unblock write.
    do_reset();
    cfg_bresp = 2'b10;
    cfg_rdata = 32'hDEAD_0003;
    base = b_cnt;
    mi_w_error = 1'b1;
    wait_until(SEL_B, base + 1, "t4_b");
    check("t4_ctlerr", ctl_error, 1'b1);
    check("t4_count", unblock_count, 2'd1);
    mi_w_error = 1'b0;
    wait_idle("t4");
    check("t4_fault", fault_status, 32'hDEAD_0003);
    check("t4_busy", busy, 1'b0);

    // SLVERR on the status read still captures rdata.
    do_reset();
    cfg_rresp = 2'b10;
    cfg_rdata = 32'h0000_0BAD;
    base = r_cnt;
    mi_r_error = 1'b1;
    wait_until(SEL_R, base + 1, "t4b_r");
    check("t4b_fault", fault_status, 32'h0000_0BAD);
    check("t4b_ctlerr", ctl_error, 1'b1);
    base = b_cnt;
    wait_until(SEL_B, base + 1, "t4b_b");
    mi_r_error = 1'b0;
    wait_idle("t4b");
    check("t4b_count", unblock_count, 2'd1);

    // Reset while stuck in WR with AWVALID high.
    do_reset();
    cfg_aw_delay = 100;
    cfg_rresp = 2'b10;
    base = w_cnt;
    mi_w_error = 1'b1;
    wait_until(SEL_W, base + 1, "t5_w");
    check("t5_awvalid_pre", awvalid, 1'b1);
    check("t5_ctlerr_pre", ctl_error, 1'b1);
    areset = 1'b1;
    tick(1);
    check("t5_awvalid", awvalid, 1'b0);
    check("t5_wvalid", wvalid, 1'b0);
    check("t5_arvalid", arvalid, 1'b0);
    check("t5_bready", bready, 1'b0);
    check("t5_count", unblock_count, 2'd0);
    check("t5_ctlerr", ctl_error, 1'b0);
    check("t5_busy", busy, 1'b0);
    areset = 1'b0;
    cfg_aw_delay = 0;
    cfg_rresp = 2'b00;
    tick(1);
    check("t5_retrigger", arvalid, 1'b1);
    base = b_cnt;
    wait_until(SEL_B, base + 1, "t5_b");
    mi_w_error = 1'b0;
    wait_idle("t5");
    check("t5_count_after", unblock_count, 2'd1);

    // Saturation of the 2-bit counter.
    do_reset();
    base = b_cnt;
    for (int k = 1; k <= 5; k++) begin
      mi_w_error = 1'b1;
      wait_until(SEL_B, base + k, "t6_b");
      mi_w_error = 1'b0;
      wait_idle("t6");
      check("t6_count", unblock_count, (k < 3) ? k : 3);
    end

    check("protocol_overlap", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
